// File: rtl/if_pkg.sv
// Shared fetch-pipeline definitions: FSM encoding, error codes, stage output record.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } if3_state_e;

  localparam logic [1:0] IF_ERR_NONE    = 2'b00;
  localparam logic [1:0] IF_ERR_ALIGN   = 2'b01;
  localparam logic [1:0] IF_ERR_TIMEOUT = 2'b10;

  typedef struct packed {
    logic [31:0] instr;
    logic [29:0] paddr;
    logic [1:0]  err;
  } if_out_t;

endpackage

// File: rtl/if3_timer.sv
// Bus-wait counter; expired flags the last allowed wait cycle so the FSM can
// close the cycle on the edge where the count reaches TIMEOUT.
module if3_timer #(
  parameter int TIMEOUT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + 8'd1;
  end

  assign expired = en && (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/if3.sv
// Fetch stage 3: one instruction-bus read per accepted address, single output
// buffer with valid/ready, flush with drain of an open bus cycle.
module if3
  import if_pkg::*;
#(
  parameter int TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if3_ready_out,
  input  logic        if3_valid_in,
  input  logic [29:0] if3_paddr_in,
  input  logic        if3_ready_in,
  output logic        if3_valid_out,
  output logic [31:0] if3_instr_out,
  output logic [29:0] if3_paddr_out,
  output logic [1:0]  if3_err_out,
  input  logic        if3_flush,
  output logic        bus_stb,
  output logic [27:0] bus_addr,
  input  logic [31:0] bus_din,
  input  logic        bus_ack
);

  if3_state_e state, state_n;
  if_out_t    obuf;
  logic       accept, aligned, tmr_clr, tmr_en, expired;

  assign if3_ready_out = ~rst & ~if3_flush &
                         ((state == IDLE) | ((state == FULL) & if3_ready_in));
  assign accept  = if3_valid_in & if3_ready_out;
  assign aligned = (if3_paddr_in[1:0] == 2'b00);

  // Counter restarts for a new fetch and again when a flush turns REQ into DRAIN.
  assign tmr_en  = ((state == REQ) | (state == DRAIN)) & ~bus_ack;
  assign tmr_clr = accept | ((state == REQ) & if3_flush);

  if3_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (expired)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (accept) state_n = aligned ? REQ : FULL;
      REQ: begin
        if (if3_flush)         state_n = (bus_ack || expired) ? IDLE : DRAIN;
        else if (bus_ack)      state_n = FULL;
        else if (expired)      state_n = FULL;
      end
      FULL: begin
        if (if3_flush)         state_n = IDLE;
        else if (accept)       state_n = aligned ? REQ : FULL;
        else if (if3_ready_in) state_n = IDLE;
      end
      DRAIN: if (bus_ack || expired) state_n = IDLE;
      default:                 state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      obuf          <= '0;
      if3_valid_out <= 1'b0;
      bus_stb       <= 1'b0;
      bus_addr      <= '0;
    end else begin
      state         <= state_n;
      if3_valid_out <= (state_n == FULL);
      bus_stb       <= (state_n == REQ) || (state_n == DRAIN);
      if (accept) begin
        obuf.paddr <= if3_paddr_in;
        if (aligned) begin
          bus_addr <= if3_paddr_in[29:2];
        end else begin
          obuf.instr <= '0;
          obuf.err   <= IF_ERR_ALIGN;
        end
      end else if (state == REQ && !if3_flush) begin
        if (bus_ack) begin
          obuf.instr <= bus_din;
          obuf.err   <= IF_ERR_NONE;
        end else if (expired) begin
          obuf.instr <= '0;
          obuf.err   <= IF_ERR_TIMEOUT;
        end
      end
    end
  end

  assign if3_instr_out = obuf.instr;
  assign if3_paddr_out = obuf.paddr;
  assign if3_err_out   = obuf.err;

endmodule

// File: tb/tb_if3.sv
// Directed bench for if3: expected output words are queued when addresses are
// driven and popped when the stage presents valid output.
module tb_if3;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if3_ready_out;
  logic        if3_valid_in;
  logic [29:0] if3_paddr_in;
  logic        if3_ready_in;
  logic        if3_valid_out;
  logic [31:0] if3_instr_out;
  logic [29:0] if3_paddr_out;
  logic [1:0]  if3_err_out;
  logic        if3_flush;
  logic        bus_stb;
  logic [27:0] bus_addr;
  logic [31:0] bus_din;
  logic        bus_ack;

  int checks   = 0;
  int failures = 0;

  if_out_t sb[$];

  if3 #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .if3_ready_out (if3_ready_out),
    .if3_valid_in  (if3_valid_in),
    .if3_paddr_in  (if3_paddr_in),
    .if3_ready_in  (if3_ready_in),
    .if3_valid_out (if3_valid_out),
    .if3_instr_out (if3_instr_out),
    .if3_paddr_out (if3_paddr_out),
    .if3_err_out   (if3_err_out),
    .if3_flush     (if3_flush),
    .bus_stb       (bus_stb),
    .bus_addr      (bus_addr),
    .bus_din       (bus_din),
    .bus_ack       (bus_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [29:0] paddr, input logic [1:0] err);
    if_out_t e;
    e.instr = instr;
    e.paddr = paddr;
    e.err   = err;
    sb.push_back(e);
  endtask

  // Compare the currently presented output word against the scoreboard head.
  task automatic pop_cmp(input string tag);
    if_out_t e;
    chk({tag, "_valid"}, 64'(if3_valid_out), 64'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_instr"}, 64'(if3_instr_out), 64'(e.instr));
      chk({tag, "_paddr"}, 64'(if3_paddr_out), 64'(e.paddr));
      chk({tag, "_err"},   64'(if3_err_out),   64'(e.err));
    end
  endtask

  initial begin
    int n;
    bit seen;
    logic [31:0] held;

    rst = 1'b1; if3_valid_in = 1'b0; if3_paddr_in = '0; if3_ready_in = 1'b0;
    if3_flush = 1'b0; bus_din = '0; bus_ack = 1'b0;
    tick(); tick();
    if3_valid_in = 1'b1;
    chk("rst_ready_out", 64'(if3_ready_out), 64'd0);
    chk("rst_valid_out", 64'(if3_valid_out), 64'd0);
    chk("rst_bus_stb",   64'(bus_stb),       64'd0);
    chk("rst_bus_addr",  64'(bus_addr),      64'd0);
    chk("rst_instr",     64'(if3_instr_out), 64'd0);
    chk("rst_err",       64'(if3_err_out),   64'd0);
    if3_valid_in = 1'b0;
    rst = 1'b0;
    tick();

    // Zero-wait fetch, then a second fetch accepted in the FULL cycle.
    if3_valid_in = 1'b1; if3_paddr_in = 30'h0000_1000; if3_ready_in = 1'b1;
    chk("zw_ready_idle", 64'(if3_ready_out), 64'd1);
    push(32'hDEAD_BEEF, 30'h0000_1000, IF_ERR_NONE);
    tick();
    if3_paddr_in = 30'h0000_1004;
    chk("zw_stb", 64'(bus_stb), 64'd1);
    chk("zw_bus_addr", 64'(bus_addr), 64'h000_0400);
    chk("zw_ready_req", 64'(if3_ready_out), 64'd0);
    bus_ack = 1'b1; bus_din = 32'hDEAD_BEEF;
    tick();
    bus_ack = 1'b0; bus_din = '0;
    pop_cmp("zw_out");
    chk("zw_ready_full", 64'(if3_ready_out), 64'd1);
    push(32'hCAFE_F00D, 30'h0000_1004, IF_ERR_NONE);
    tick();
    if3_valid_in = 1'b0;
    chk("zw_valid_one_cycle", 64'(if3_valid_out), 64'd0);
    chk("zw2_stb", 64'(bus_stb), 64'd1);
    chk("zw2_bus_addr", 64'(bus_addr), 64'h000_0401);
    bus_ack = 1'b1; bus_din = 32'hCAFE_F00D; if3_ready_in = 1'b0;
    tick();
    bus_ack = 1'b0; bus_din = '0;
    pop_cmp("bp_out");

    // Back-pressure: output held, no new accept, no bus activity.
    if3_valid_in = 1'b1; if3_paddr_in = 30'h0000_2000;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(if3_valid_out), 64'd1);
      chk("bp_instr", 64'(if3_instr_out), 64'hCAFE_F00D);
      chk("bp_ready_out", 64'(if3_ready_out), 64'd0);
      chk("bp_no_stb", 64'(bus_stb), 64'd0);
      tick();
    end
    if3_valid_in = 1'b0; if3_ready_in = 1'b1;
    tick();
    chk("bp_released", 64'(if3_valid_out), 64'd0);

    // Misaligned address: no bus cycle, error word the next cycle.
    if3_valid_in = 1'b1; if3_paddr_in = 30'h0000_0002;
    push(32'h0, 30'h0000_0002, IF_ERR_ALIGN);
    tick();
    if3_valid_in = 1'b0;
    chk("mis_no_stb", 64'(bus_stb), 64'd0);
    pop_cmp("mis_out");
    tick();

    // Timeout with TIMEOUT=4 and no ack.
    if3_valid_in = 1'b1; if3_paddr_in = 30'h0000_3000;
    push(32'h0, 30'h0000_3000, IF_ERR_TIMEOUT);
    tick();
    if3_valid_in = 1'b0;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (if3_valid_out) seen = 1'b1;
      else begin
        if (bus_stb) n++;
        tick();
      end
    end
    chk("to_valid_seen", 64'(seen), 64'd1);
    chk("to_stb_cycles", 64'(n), 64'd4);
    chk("to_stb_dropped", 64'(bus_stb), 64'd0);
    if (seen) pop_cmp("to_out");
    tick();

    // Flush in the second REQ cycle, ack on the third DRAIN cycle.
    if3_valid_in = 1'b1; if3_paddr_in = 30'h0000_4000;
    tick();
    if3_valid_in = 1'b0;
    chk("fl_stb_req1", 64'(bus_stb), 64'd1);
    tick();
    if3_flush = 1'b1;
    chk("fl_stb_req2", 64'(bus_stb), 64'd1);
    tick();
    if3_flush = 1'b0;
    held = 32'(bus_addr);
    chk("fl_drain_addr", 64'(held), 64'h000_1000);
    for (int i = 0; i < 3; i++) begin
      chk("fl_drain_stb", 64'(bus_stb), 64'd1);
      chk("fl_drain_valid", 64'(if3_valid_out), 64'd0);
      chk("fl_drain_ready", 64'(if3_ready_out), 64'd0);
      if (i == 2) begin bus_ack = 1'b1; bus_din = 32'h1234_5678; end
      tick();
    end
    bus_ack = 1'b0; bus_din = '0;
    chk("fl_idle_stb", 64'(bus_stb), 64'd0);
    chk("fl_idle_ready", 64'(if3_ready_out), 64'd1);
    for (int i = 0; i < 2; i++) begin
      chk("fl_no_valid", 64'(if3_valid_out), 64'd0);
      tick();
    end

    // Reset while waiting on the bus; a late ack must be ignored.
    if3_valid_in = 1'b1; if3_paddr_in = 30'h0000_6000;
    tick();
    if3_valid_in = 1'b0;
    tick();
    chk("rr_stb_before", 64'(bus_stb), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_stb", 64'(bus_stb), 64'd0);
    chk("rr_valid", 64'(if3_valid_out), 64'd0);
    chk("rr_addr", 64'(bus_addr), 64'd0);
    bus_ack = 1'b1; bus_din = 32'h0000_0BAD;
    tick();
    bus_ack = 1'b0; bus_din = '0;
    chk("rr_late_ack_valid", 64'(if3_valid_out), 64'd0);
    chk("rr_late_ack_instr", 64'(if3_instr_out), 64'd0);
    tick();
    chk("rr_late_ack_valid2", 64'(if3_valid_out), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if3.md
# if3

Instruction fetch stage 3, the memory access stage. Consumes the translated physical address from fetch stage 2 and runs one read cycle per instruction on the instruction bus. Buffers the fetched word and hands it downstream with a valid/ready handshake. Also provides flush, misalignment detection and a bus-timeout abort.

## Interface
- TIMEOUT, 200, bus wait cycles before abort; legal range 1..255.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high (clock clk)
- if3_ready_out  out  1  stage accepts a new address this cycle
- if3_valid_in  in  1  upstream address valid
- if3_paddr_in  in  30  physical byte address
- if3_ready_in  in  1  downstream accepts the output this cycle
- if3_valid_out  out  1  output word valid
- if3_instr_out  out  32  fetched instruction
- if3_paddr_out  out  30  address of the output word
- if3_err_out  out  2  00 ok, 01 misaligned, 10 bus timeout
- if3_flush  in  1  discard all buffered and in-flight work
- bus_stb  out  1  bus read request
- bus_addr  out  28  word address, equal to paddr[29:2]
- bus_din  in  32  read data
- bus_ack  in  1  read completes this cycle

## Operation
- FSM states:
  - IDLE: buffer empty.
  - REQ: bus cycle active.
  - FULL: output held.
  - DRAIN: flushed bus cycle still open.
- if3_ready_out = ~if3_flush & (IDLE | (FULL & if3_ready_in)). This is combinational from if3_ready_in.
- Accept means if3_valid_in & if3_ready_out at a clock edge. On accept, the stage latches paddr.
  - If paddr[1:0] == 0, go to REQ and clear the timeout counter.
  - Otherwise go to FULL with err=01 and instr=0. No bus cycle is issued.
- REQ:
  - bus_stb=1 and bus_addr=paddr_buf[29:2], both held stable until the cycle ends.
  - On bus_ack: latch bus_din, err=00, go to FULL.
  - On counter reaching TIMEOUT without ack: drop stb, instr=0, err=10, go to FULL.
  - The counter is 8-bit and increments each REQ cycle without ack.
- FULL:
  - if3_valid_out=1. instr, paddr and err stay stable until consumed.
  - if3_ready_in with no new accept: go to IDLE.
  - if3_ready_in with a simultaneous accept: go directly to REQ, or to FULL for a misaligned address.
- Flush has priority over everything:
  - From IDLE or FULL: go to IDLE and drop valid_out.
  - From REQ: if bus_ack is present the same cycle, go to IDLE. Otherwise go to DRAIN.
  - DRAIN keeps bus_stb=1 until bus_ack (or timeout), discards the data, then goes to IDLE.
  - if3_ready_out=0 and if3_valid_out=0 throughout DRAIN.
  - Flush while in DRAIN: stay in DRAIN.
- Ack arriving outside REQ/DRAIN is ignored.

## Timing
- Reset values:
  - state IDLE
  - if3_valid_out 0, if3_instr_out 0, if3_paddr_out 0, if3_err_out 00
  - bus_stb 0, bus_addr 0, counter 0
- The reset cycle forces ready_out=0.
- Latency:
  - Accept at edge k gives bus_stb=1 during cycle k+1.
  - Ack sampled at edge k+n gives valid_out=1 during cycle k+n+1.
- Throughput with a zero-wait bus (ack in first REQ cycle) is one instruction every 2 cycles.
- Timeout: stb is high for exactly TIMEOUT cycles, then err=10 appears the next cycle.
- Misaligned path: valid_out appears the cycle after accept.
- All outputs except if3_ready_out are registered.

## Structure
- Shared package if_pkg holds:
  - the FSM state encoding (IDLE, REQ, FULL, DRAIN)
  - the error codes IF_ERR_NONE=2'b00, IF_ERR_ALIGN=2'b01, IF_ERR_TIMEOUT=2'b10
- The same error codes are reused by later fetch/decode stages.
- One sub-module, if3_timer: an 8-bit counter with clear, enable and expired-at-TIMEOUT output. It is also used in DRAIN.

## Test plan
- Zero-wait fetch: paddr 0x00001000, ack in the first REQ cycle with bus_din 0xDEADBEEF, if3_ready_in held 1. Expect bus_addr 0x0000400; if3_instr_out 0xDEADBEEF, err 00, valid for one cycle; next address accepted the same cycle.
- Back-pressure: if3_ready_in=0 for 5 cycles after the data arrives. Expect output stable, if3_ready_out=0, no second bus_stb.
- Misaligned: paddr 0x00000002. Expect no bus_stb; next cycle valid_out=1, err 01, instr 0.
- Timeout: TIMEOUT=4, bus_ack never asserted. Expect bus_stb high for exactly 4 cycles, then valid_out with err 10 and instr 0.
- Flush mid-cycle: flush in the second REQ cycle, ack 3 cycles later with 0x12345678. Expect DRAIN with stb held until ack, valid_out never asserted, IDLE afterwards.
- Reset mid-REQ: rst during a bus wait. Expect bus_stb=0 and valid_out=0 next cycle; a later ack is ignored.
